// File: rtl/spike_frame_pipe_out.sv
// Spike-count frame builder feeding a first-word-fall-through FIFO that drains
// to a block-throttled host pipe endpoint (ep_ready/ep_read handshake).
module spike_frame_pipe_out #(
    parameter int DEPTH_LOG2  = 10,
    parameter int BLOCK_WORDS = 256,
    parameter int CNT_W       = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  tick,
    input  logic                  spike,
    input  logic                  clear_stats,
    input  logic                  ep_read,
    input  logic                  ep_blockstrobe,
    output logic [15:0]           ep_datain,
    output logic                  ep_ready,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic [15:0]           drop_count,
    output logic                  underflow
);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int SEQ_W  = 16 - CNT_W;
    localparam int FILL_W = DEPTH_LOG2 + 1;

    // Block boundaries carry no information for this source.
    logic unused_blockstrobe;
    assign unused_blockstrobe = ep_blockstrobe;

    logic                  spike_q_reg;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [SEQ_W-1:0]      seq_reg, seq_next;
    logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
    logic [FILL_W-1:0]     fill_reg, fill_next;
    logic [15:0]           drop_reg;
    logic                  underflow_reg;
    logic                  ready_reg;

    logic [15:0]           mem [DEPTH];
    logic [15:0]           rd_data_reg;
    logic [15:0]           bypass_data_reg;
    logic                  bypass_reg;
    logic                  head_valid_reg;

    logic                  rise, capture, empty, full;
    logic                  pop_ok, push_ok, drop;
    logic [CNT_W-1:0]      cnt_inc;
    logic [15:0]           frame;

    always_comb begin
        rise    = spike & ~spike_q_reg;
        // An edge on the closing cycle still belongs to the frame being closed.
        cnt_inc = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(rise);
        frame   = {seq_reg, cnt_inc};
        capture = tick & enable;
        empty   = (fill_reg == '0);
        full    = (fill_reg == FILL_W'(DEPTH));
        pop_ok  = ep_read & ~empty;
        push_ok = capture & (~full | pop_ok);
        drop    = capture & ~push_ok;

        wr_ptr_next = push_ok ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
        rd_ptr_next = pop_ok  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

        fill_next = fill_reg;
        case ({push_ok, pop_ok})
            2'b10:   fill_next = fill_reg + 1'b1;
            2'b01:   fill_next = fill_reg - 1'b1;
            default: fill_next = fill_reg;
        endcase

        cnt_next = cnt_inc;
        seq_next = seq_reg;
        if (tick) begin
            cnt_next = '0;
            if (enable) begin
                seq_next = seq_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            spike_q_reg     <= 1'b0;
            cnt_reg         <= '0;
            seq_reg         <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            fill_reg        <= '0;
            drop_reg        <= '0;
            underflow_reg   <= 1'b0;
            ready_reg       <= 1'b0;
            bypass_reg      <= 1'b0;
            bypass_data_reg <= '0;
            head_valid_reg  <= 1'b0;
        end else begin
            spike_q_reg <= spike;
            cnt_reg     <= cnt_next;
            seq_reg     <= seq_next;
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            fill_reg    <= fill_next;
            ready_reg   <= (fill_next >= FILL_W'(BLOCK_WORDS));

            if (clear_stats) begin
                drop_reg      <= '0;
                underflow_reg <= 1'b0;
            end else begin
                if (drop && drop_reg != 16'hFFFF) begin
                    drop_reg <= drop_reg + 16'd1;
                end
                if (ep_read && empty) begin
                    underflow_reg <= 1'b1;
                end
            end

            // The word landing in the new head slot this cycle is not yet
            // readable from memory, so it is forwarded around the RAM.
            head_valid_reg  <= (fill_next != '0);
            bypass_reg      <= push_ok && (wr_ptr_reg == rd_ptr_next);
            bypass_data_reg <= frame;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= frame;
        end
        rd_data_reg <= mem[rd_ptr_next];
    end

    assign ep_datain  = !head_valid_reg ? 16'h0000 :
                        (bypass_reg ? bypass_data_reg : rd_data_reg);
    assign ep_ready   = ready_reg;
    assign fill_level = fill_reg;
    assign drop_count = drop_reg;
    assign underflow  = underflow_reg;

endmodule
